sobel_stream: RTL
=================

Name: sobel_stream

Overview:
Streaming 3x3 Sobel edge detector for raster-order pixel streams, one pixel per clock.
- Builds the 3x3 window internally using two line buffers, so the upstream does not supply nine taps.
- Computes signed Gx/Gy gradients and outputs a gradient magnitude. The magnitude mode is selectable per frame: L1, alpha-max-beta-min, or binary threshold.
- Sits between the pixel source (camera/frame reader) and the downstream edge/post-processing stages.

Parameters:
PIX_W, 8, input pixel width (unsigned)
OUT_W, 8, output magnitude width (unsigned, saturating)
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
G_W, PIX_W+3, signed gradient width; holds ±4*(2^PIX_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  pixel present this cycle; no backpressure
in_sof  in  1  qualifies in_valid; this pixel is (row 0, col 0)
in_pixel  in  PIX_W  pixel data
mode  in  2  0=L1, 1=alpha-max-beta-min, 2=threshold, 3=same as 0
thresh  in  G_W+1  threshold for mode 2
out_valid  out  1  magnitude valid
out_sof  out  1  first interior output of a frame
out_eol  out  1  last interior output of a line
out_pixel  out  OUT_W  magnitude

Behaviour:
Reset:
- rst is synchronous and active-high on clk.
- rst clears the row/col counters, the pipeline valids, the frame-armed flag and the latched mode/thresh.
- All outputs read 0 on the cycle after rst.
- Line-buffer contents are not cleared.
- Reset mid-frame: no out_valid until the next in_sof pixel.

Input and counters:
- Pixels are accepted only when in_valid=1. Cycles with in_valid=0 are bubbles: counters and pipeline state hold, and no out_valid is generated from them.
- in_sof with in_valid:
  - forces this pixel to (0,0) and arms the frame;
  - latches mode and thresh, which stay constant for the whole frame;
  - a mid-frame in_sof aborts the current frame and restarts from (0,0).
- Col wraps IMG_W-1 -> 0 and increments row.
- After pixel (IMG_H-1, IMG_W-1) the frame disarms. Further pixels are ignored (no buffer write, no output) until the next in_sof.
- in_valid without in_sof while disarmed is ignored.

Window:
- Line buffers hold rows r-1 and r-2. A window is complete when the accepted pixel is at row>=2 and col>=2.
- The window is centred on (row-1, col-1), with taps p0..p8 in row-major order (top-left = p0).
- Border pixels produce no output. Each frame yields exactly (IMG_W-2)*(IMG_H-2) outputs.

Pipeline, fixed 2-stage:
- Stage 1 registers:
  - Gx = (p2+2p5+p8)-(p0+2p3+p6)
  - Gy = (p6+2p7+p8)-(p0+2p1+p2)
  - Both are signed G_W and exact, with no clipping.
- Stage 2 registers the output. out_valid asserts exactly 2 cycles after the completing pixel's accept edge, provided no rst occurs in between.
- Stage 2 magnitude: a = max(|Gx|,|Gy|), b = min(|Gx|,|Gy|), both unsigned G_W.
  - mode 0: m = a+b.
  - mode 1:
    - t = floor(7a/8) + floor(b/2), plus 1 if (7a mod 8)>4 or b is odd.
    - m = max(t, a).
  - mode 2: out_pixel = all-ones if a+b >= thresh, else 0.
  - Modes 0/1: out_pixel = min(m, 2^OUT_W-1), a saturating clip that never wraps.
- out_sof is set on the first output after the arming in_sof. out_eol is set on the output for window col IMG_W-2.
- All outputs are registered. out_sof, out_eol and out_pixel are 0 when out_valid=0.

Decomposition:
- Shared package/include sobel_pkg:
  - MODE_L1, MODE_AMBM, MODE_THR constants;
  - the Sobel coefficient constants;
  - a function computing G_W from PIX_W.
- Sub-module sobel_line_buf (depth IMG_W, width PIX_W): single-port read-before-write delay line. Two instances are cascaded.

Test Plan:
Common parameters for all scenarios: IMG_W=8, IMG_H=4, PIX_W=OUT_W=8.
1. Flat frame, all 100, mode 0 -> exactly 12 outputs, all 0; out_sof on the first, out_eol on the 6th and 12th.
2. Vertical step (cols 0-3 = 0, cols 4-7 = 10), mode 0 -> rows 1-2: cols 3,4 give 40, others 0. Mode 1 -> same values: a=40, t=35, max=40.
3. Frame producing Gx=40, Gy=-20 at one centre -> mode 0 gives 60, mode 1 gives 45. Step of 255 (Gx=1020) -> mode 0 saturates to 255.
4. Mode 2 with thresh=30 on scenario 2 -> 255 at cols 3,4, else 0. Changing mode/thresh mid-frame has no effect until the next in_sof.
5. Random in_valid bubbles (~50%) on scenario 2 -> identical output sequence; each out_valid is exactly 2 clks after its completing accept.
6. rst asserted at pixel (2,3), then a new in_sof frame -> out_valid low from the cycle after rst until the new frame, then 12 correct outputs. A second in_sof mid-frame -> restart, with no stale-window outputs.

Source files
------------

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_pkg
//  Purpose  : Shared constants and helpers for the sobel_stream edge detector:
//             magnitude-mode encodings, Sobel kernel weights and the gradient
//             width calculation.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    // Magnitude modes, latched once per frame. Encoding 3 behaves as L1.
    localparam logic [1:0] MODE_L1   = 2'd0;
    localparam logic [1:0] MODE_AMBM = 2'd1;
    localparam logic [1:0] MODE_THR  = 2'd2;

    // Sobel kernel weights: corner taps carry 1, edge-centre taps carry 2.
    localparam int SOBEL_K_OUTER  = 1;
    localparam int SOBEL_K_CENTRE = 2;

    // A 3x3 Sobel sum reaches +/-4*(2^pix_w-1): two extra magnitude bits
    // plus a sign bit.
    function automatic int calc_g_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_line_buf
//  Purpose  : One-line delay for the Sobel window. Single-port memory indexed
//             by the current column: the read returns the value stored one
//             line earlier at that column, and the write of the new value
//             lands on the same clock edge (read-before-write).
//  Ports    : clk      - clock
//             i_we     - write strobe (pixel accepted)
//             i_addr   - column address
//             i_wdata  - value to store
//             o_rdata  - value stored at i_addr one line ago
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [A_W-1:0]   i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are deliberately not reset; a fresh frame overwrites every
    // location before it is ever read back into a valid window.
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign o_rdata = mem_q[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_stream.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_stream
//  Purpose  : Streaming 3x3 Sobel edge detector, one raster-order pixel per
//             clock, no backpressure. Builds the window from two cascaded
//             line buffers, computes signed Gx/Gy and emits a per-frame
//             selectable magnitude (L1, alpha-max-beta-min or threshold).
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             in_valid        - pixel present this cycle
//             in_sof          - with in_valid: pixel is (0,0), arms frame,
//                               latches mode/thresh
//             in_pixel        - unsigned pixel
//             mode, thresh    - magnitude mode and threshold (per frame)
//             out_valid       - magnitude valid
//             out_sof/out_eol - first output of frame / last of a line
//             out_pixel       - saturated magnitude
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int OUT_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int G_W   = calc_g_w(PIX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic [1:0]       mode,
    input  logic [G_W:0]     thresh,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [OUT_W-1:0] out_pixel
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int M_W   = G_W + 1;
    localparam int E_W   = (M_W > OUT_W) ? M_W : OUT_W;

    localparam logic [COL_W-1:0] c_last_col = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);
    localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);
    localparam logic signed [G_W-1:0] c_k_outer  = G_W'(SOBEL_K_OUTER);
    localparam logic signed [G_W-1:0] c_k_centre = G_W'(SOBEL_K_CENTRE);
    localparam logic [E_W-1:0] c_out_max = E_W'((64'd1 << OUT_W) - 64'd1);

    // ------------------------------------------------------------------
    // Frame position and per-frame configuration
    // ------------------------------------------------------------------
    logic             armed_q, armed_d;
    logic             pend_sof_q, pend_sof_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       mode_q, mode_d;
    logic [G_W:0]     thresh_q, thresh_d;

    logic             w_accept;
    logic             w_complete;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;

    always_comb begin
        w_accept   = in_valid && (in_sof || armed_q);
        // in_sof overrides whatever position the counters held.
        w_row      = in_sof ? '0 : row_q;
        w_col      = in_sof ? '0 : col_q;
        w_complete = w_accept && (w_row >= c_row_two) && (w_col >= c_col_two);

        armed_d    = armed_q;
        pend_sof_d = pend_sof_q;
        row_d      = row_q;
        col_d      = col_q;
        mode_d     = mode_q;
        thresh_d   = thresh_q;

        if (w_accept) begin
            if (in_sof) begin
                armed_d    = 1'b1;
                pend_sof_d = 1'b1;
                mode_d     = mode;
                thresh_d   = thresh;
            end
            row_d = w_row;
            if (w_col == c_last_col) begin
                col_d = '0;
                if (w_row == c_last_row) begin
                    row_d   = '0;
                    armed_d = 1'b0;
                end else begin
                    row_d = w_row + 1'b1;
                end
            end else begin
                col_d = w_col + 1'b1;
            end
            if (w_complete) begin
                pend_sof_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb0 yields row r-1, lb1 (fed by lb0) yields row r-2
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] w_lb0_rdata;
    logic [PIX_W-1:0] w_lb1_rdata;

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .A_W   (COL_W)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col),
        .i_wdata (in_pixel),
        .o_rdata (w_lb0_rdata)
    );

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .A_W   (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_col),
        .i_wdata (w_lb0_rdata),
        .o_rdata (w_lb1_rdata)
    );

    // ------------------------------------------------------------------
    // Window register: taps p0..p8 row-major, shifted left on every accept
    // so the newest column lands in p2/p5/p8.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];
    logic             win_valid_q, win_valid_d;
    logic             win_sof_q, win_sof_d;
    logic             win_eol_q, win_eol_d;

    always_comb begin
        win_d = win_q;
        if (w_accept) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = w_lb1_rdata;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = w_lb0_rdata;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = in_pixel;
        end
        win_valid_d = w_complete;
        win_sof_d   = w_complete && pend_sof_q;
        // Accepted column IMG_W-1 centres the window on column IMG_W-2.
        win_eol_d   = w_complete && (w_col == c_last_col);
    end

    // ------------------------------------------------------------------
    // Stage 1: signed gradients
    // ------------------------------------------------------------------
    logic signed [G_W-1:0] w_tap [9];
    logic signed [G_W-1:0] s1_gx_q, s1_gx_d;
    logic signed [G_W-1:0] s1_gy_q, s1_gy_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sof_q, s1_sof_d;
    logic                  s1_eol_q, s1_eol_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic [G_W:0]          s1_thresh_q, s1_thresh_d;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_tap[i] = $signed({{(G_W-PIX_W){1'b0}}, win_q[i]});
        end
        s1_gx_d = c_k_outer  * (w_tap[2] + w_tap[8] - w_tap[0] - w_tap[6])
                + c_k_centre * (w_tap[5] - w_tap[3]);
        s1_gy_d = c_k_outer  * (w_tap[6] + w_tap[8] - w_tap[0] - w_tap[2])
                + c_k_centre * (w_tap[7] - w_tap[1]);
        s1_valid_d  = win_valid_q;
        s1_sof_d    = win_sof_q;
        s1_eol_d    = win_eol_q;
        // Sampled here, a following frame's in_sof cannot retune the tail
        // of the frame still in flight.
        s1_mode_d   = mode_q;
        s1_thresh_d = thresh_q;
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude and saturation
    // ------------------------------------------------------------------
    logic [G_W-1:0]   w_ax, w_ay, w_a, w_b;
    logic [M_W-1:0]   w_sum;
    logic [G_W+2:0]   w_7a;
    logic             w_round;
    logic [M_W-1:0]   w_t;
    logic [M_W-1:0]   w_m;
    logic [E_W-1:0]   w_m_ext;
    logic [OUT_W-1:0] w_sat;

    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eol_q, out_eol_d;
    logic [OUT_W-1:0] out_pixel_q, out_pixel_d;

    always_comb begin
        w_ax    = s1_gx_q[G_W-1] ? $unsigned(-s1_gx_q) : $unsigned(s1_gx_q);
        w_ay    = s1_gy_q[G_W-1] ? $unsigned(-s1_gy_q) : $unsigned(s1_gy_q);
        w_a     = (w_ax >= w_ay) ? w_ax : w_ay;
        w_b     = (w_ax >= w_ay) ? w_ay : w_ax;
        w_sum   = {1'b0, w_a} + {1'b0, w_b};
        // 7a computed as 8a - a; the low three bits are the remainder mod 8.
        w_7a    = {w_a, 3'b000} - {3'b000, w_a};
        w_round = (w_7a[2:0] > 3'd4) || w_b[0];
        w_t     = {1'b0, w_7a[G_W+2:3]} + {2'b00, w_b[G_W-1:1]}
                + {{G_W{1'b0}}, w_round};

        case (s1_mode_q)
            MODE_AMBM: w_m = (w_t > {1'b0, w_a}) ? w_t : {1'b0, w_a};
            default:   w_m = w_sum;
        endcase
        w_m_ext = E_W'(w_m);
        w_sat   = (w_m_ext > c_out_max) ? {OUT_W{1'b1}} : w_m_ext[OUT_W-1:0];

        out_valid_d = s1_valid_q;
        out_sof_d   = s1_valid_q && s1_sof_q;
        out_eol_d   = s1_valid_q && s1_eol_q;
        out_pixel_d = '0;
        if (s1_valid_q) begin
            if (s1_mode_q == MODE_THR) begin
                out_pixel_d = (w_sum >= s1_thresh_q) ? {OUT_W{1'b1}} : '0;
            end else begin
                out_pixel_d = w_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q     <= 1'b0;
            pend_sof_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            mode_q      <= '0;
            thresh_q    <= '0;
            win_valid_q <= 1'b0;
            win_sof_q   <= 1'b0;
            win_eol_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_mode_q   <= '0;
            s1_thresh_q <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            armed_q     <= armed_d;
            pend_sof_q  <= pend_sof_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mode_q      <= mode_d;
            thresh_q    <= thresh_d;
            win_valid_q <= win_valid_d;
            win_sof_q   <= win_sof_d;
            win_eol_q   <= win_eol_d;
            s1_valid_q  <= s1_valid_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            s1_mode_q   <= s1_mode_d;
            s1_thresh_q <= s1_thresh_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_pixel_q <= out_pixel_d;
        end
    end

    // Datapath registers are only consumed when their valid is set.
    always_ff @(posedge clk) begin
        win_q   <= win_d;
        s1_gx_q <= s1_gx_d;
        s1_gy_q <= s1_gy_d;
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_pixel = out_pixel_q;

endmodule
`default_nettype wire
